// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port; grant held until the owner drops req.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating priority under contention (default: r0 fixed priority).
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_ready,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_ready,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t              state_q;
    logic                owner_q;
    logic                m_req_q;
    logic                m_we_q;
    logic [ADDR_W-1:0]   m_addr_q;
    logic [DATA_W-1:0]   m_wdata_q;
    logic                r0_ready_q;
    logic                r1_ready_q;
    logic [DATA_W-1:0]   r0_rdata_q;
    logic [DATA_W-1:0]   r1_rdata_q;
    logic [1:0]          grant_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                last_owner_q;
`endif

    logic                any_req;
    logic                win_d;
    logic                own_req;

    always_comb begin
        any_req = r0_req | r1_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        // Under contention the requester that was not served last wins.
        if (r0_req && r1_req) begin
            win_d = ~last_owner_q;
        end else begin
            win_d = r1_req & ~r0_req;
        end
`else
        win_d = ~r0_req;
`endif
        own_req = owner_q ? r1_req : r0_req;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            r0_ready_q   <= 1'b0;
            r1_ready_q   <= 1'b0;
            r0_rdata_q   <= '0;
            r1_rdata_q   <= '0;
            grant_q      <= 2'b00;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_owner_q <= 1'b1;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q   <= win_d;
                        m_req_q   <= 1'b1;
                        m_we_q    <= win_d ? r1_we : r0_we;
                        m_addr_q  <= win_d ? r1_addr : r0_addr;
                        m_wdata_q <= win_d ? r1_wdata : r0_wdata;
                        grant_q   <= win_d ? 2'b10 : 2'b01;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (m_ready) begin
                        m_req_q <= 1'b0;
                        m_we_q  <= 1'b0;
                        if (own_req) begin
                            if (owner_q) begin
                                r1_ready_q <= 1'b1;
                                if (!m_we_q) r1_rdata_q <= m_rdata;
                            end else begin
                                r0_ready_q <= 1'b1;
                                if (!m_we_q) r0_rdata_q <= m_rdata;
                            end
                            state_q <= DONE;
                        end else begin
                            // Owner walked away: finish the memory cycle silently.
                            grant_q <= 2'b00;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                            last_owner_q <= owner_q;
`endif
                            state_q <= IDLE;
                        end
                    end
                end
                DONE: begin
                    if (!own_req) begin
                        r0_ready_q <= 1'b0;
                        r1_ready_q <= 1'b0;
                        grant_q    <= 2'b00;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_owner_q <= owner_q;
`endif
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign r0_ready = r0_ready_q;
    assign r1_ready = r1_ready_q;
    assign r0_rdata = r0_rdata_q;
    assign r1_rdata = r1_rdata_q;
    assign grant    = grant_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(grant_q));
    a_mreq_busy: assert property (@(posedge clk) disable iff (!rst)
        m_req_q |-> state_q == BUSY);
    a_ready_excl: assert property (@(posedge clk) disable iff (!rst)
        !(r0_ready_q && r1_ready_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a transaction-level model.
// Build with MEM_ARB_ROUND_ROBIN_EN to check the alternating-priority variant.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [1:0] we;
    logic [7:0] addr [2];
    logic [7:0] wdata [2];
    logic [7:0] r0_rdata, r1_rdata;
    logic       r0_ready, r1_ready;
    logic       m_req, m_we, m_ready;
    logic [7:0] m_addr, m_wdata;
    logic [7:0] m_rdata;
    logic [1:0] grant;

    // bus-side memory model
    logic [7:0] mem [256];
    logic       mem_init = 1'b0;
    logic       mem_auto = 1'b1;
    logic       auto_rdy = 1'b0;
    logic       man_rdy = 1'b0;
    int         lat = 1;
    int         cnt = 0;

    // reference model state
    logic [7:0] ref_mem [256];
    logic [7:0] exp_rd [2];
    int         last = 1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign m_ready = mem_auto ? auto_rdy : man_rdy;

    mem_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .r0_req   (req[0]),
        .r0_we    (we[0]),
        .r0_addr  (addr[0]),
        .r0_wdata (wdata[0]),
        .r0_rdata (r0_rdata),
        .r0_ready (r0_ready),
        .r1_req   (req[1]),
        .r1_we    (we[1]),
        .r1_addr  (addr[1]),
        .r1_wdata (wdata[1]),
        .r1_rdata (r1_rdata),
        .r1_ready (r1_ready),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ready  (m_ready),
        .grant    (grant)
    );

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
            mem[8'hE0] = 8'h01;
            m_rdata = 8'h00;
            mem_init = 1'b1;
        end else if (mem_auto) begin
            if (auto_rdy) begin
                auto_rdy = 1'b0;
                cnt = 0;
            end else if (m_req) begin
                if (cnt >= lat) begin
                    auto_rdy = 1'b1;
                    m_rdata = mem[m_addr];
                    if (m_we) mem[m_addr] = m_wdata;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic rdy(input int w);
        return (w == 1) ? r1_ready : r0_ready;
    endfunction

    function automatic logic [7:0] rd(input int w);
        return (w == 1) ? r1_rdata : r0_rdata;
    endfunction

    function automatic int pick(input logic [1:0] m);
        if (m == 2'b01) return 0;
        if (m == 2'b10) return 1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return 1 - last;
`else
        return 0;
`endif
    endfunction

    task automatic serve(input int who);
        bit ok;
        int oth;
        oth = 1 - who;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rdy(who)) begin
                ok = 1'b1;
                break;
            end
        end
        chk("ready_timeout", 32'(ok), 32'd1);
        chk("grant", 32'(grant), (who == 1) ? 32'd2 : 32'd1);
        chk("other_ready", 32'(rdy(oth)), 32'd0);
        if (we[who]) begin
            ref_mem[addr[who]] = wdata[who];
            chk("mem_write", 32'(mem[addr[who]]), 32'(wdata[who]));
        end else begin
            exp_rd[who] = ref_mem[addr[who]];
        end
        chk("rdata", 32'(rd(who)), 32'(exp_rd[who]));
        chk("other_rdata", 32'(rd(oth)), 32'(exp_rd[oth]));
        req[who] = 1'b0;
        last = who;
        tick();
        chk("release_grant", 32'(grant), 32'd0);
        chk("release_ready", 32'(rdy(who)), 32'd0);
    endtask

    initial begin
        logic [1:0] msk;
        int w;
        rst = 1'b0;
        req = 2'b00;
        we = 2'b00;
        addr[0] = 8'h00; addr[1] = 8'h00;
        wdata[0] = 8'h00; wdata[1] = 8'h00;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
        ref_mem[8'hE0] = 8'h01;
        exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
        repeat (3) tick();
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_m_we", 32'(m_we), 32'd0);
        chk("rst_m_addr", 32'(m_addr), 32'd0);
        chk("rst_m_wdata", 32'(m_wdata), 32'd0);
        chk("rst_ready", 32'({r0_ready, r1_ready}), 32'd0);
        chk("rst_rdata", 32'({r0_rdata, r1_rdata}), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        rst = 1'b1;
        tick();

        // single read with one-cycle memory latency
        lat = 1;
        addr[0] = 8'hE0; we[0] = 1'b0; req[0] = 1'b1;
        tick();
        chk("rd_m_req", 32'(m_req), 32'd1);
        chk("rd_m_addr", 32'(m_addr), 32'hE0);
        chk("rd_grant", 32'(grant), 32'd1);
        chk("rd_early_ready", 32'(r0_ready), 32'd0);
        tick();
        chk("rd_ready_e1", 32'(r0_ready), 32'd0);
        tick();
        chk("rd_ready_e2", 32'(r0_ready), 32'd1);
        chk("rd_rdata", 32'(r0_rdata), 32'h01);
        chk("rd_m_req_off", 32'(m_req), 32'd0);
        tick();
        chk("rd_hold_ready", 32'(r0_ready), 32'd1);
        chk("rd_hold_grant", 32'(grant), 32'd1);
        req[0] = 1'b0;
        exp_rd[0] = 8'h01;
        last = 0;
        tick();
        chk("rd_rel_grant", 32'(grant), 32'd0);
        chk("rd_rel_ready", 32'(r0_ready), 32'd0);

        // r1 write
        addr[1] = 8'h10; wdata[1] = 8'hA5; we[1] = 1'b1; req[1] = 1'b1;
        tick();
        chk("wr_m_we", 32'(m_we), 32'd1);
        chk("wr_m_wdata", 32'(m_wdata), 32'hA5);
        chk("wr_grant", 32'(grant), 32'd2);
        chk("wr_r0_ready", 32'(r0_ready), 32'd0);
        serve(1);
        we[1] = 1'b0;

        // contention
        lat = $urandom_range(0, 2);
        addr[0] = 8'hE0; addr[1] = 8'h10;
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            w = pick(2'b11);
            serve(w);
            if (k < 3) req[w] = 1'b1;
            else req[1 - w] = 1'b0;
        end
        tick();
        chk("cont_idle", 32'(grant), 32'd0);

        // address held while busy
        lat = 2;
        addr[0] = 8'h20; we[0] = 1'b0; req[0] = 1'b1;
        tick();
        chk("hold_addr0", 32'(m_addr), 32'h20);
        addr[0] = 8'h30; we[0] = 1'b1; wdata[0] = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!m_req) break;
            chk("hold_addr", 32'(m_addr), 32'h20);
            chk("hold_we", 32'(m_we), 32'd0);
        end
        exp_rd[0] = ref_mem[8'h20];
        chk("hold_ready", 32'(r0_ready), 32'd1);
        chk("hold_rdata", 32'(r0_rdata), 32'(exp_rd[0]));
        req[0] = 1'b0; we[0] = 1'b0;
        last = 0;
        tick();
        chk("hold_rel", 32'(grant), 32'd0);

        // abort with r1 pending
        lat = 3;
        addr[0] = 8'h05; req[0] = 1'b1;
        tick();
        chk("ab_grant", 32'(grant), 32'd1);
        addr[1] = 8'h42; we[1] = 1'b0; req[1] = 1'b1;
        tick();
        req[0] = 1'b0;
        chk("ab_m_req1", 32'(m_req), 32'd1);
        tick();
        chk("ab_m_req2", 32'(m_req), 32'd1);
        chk("ab_ready2", 32'(r0_ready), 32'd0);
        tick();
        chk("ab_m_req3", 32'(m_req), 32'd1);
        tick();
        chk("ab_idle_grant", 32'(grant), 32'd0);
        chk("ab_ready", 32'(r0_ready), 32'd0);
        chk("ab_m_req_off", 32'(m_req), 32'd0);
        chk("ab_rdata", 32'(r0_rdata), 32'(exp_rd[0]));
        last = 0;
        serve(1);

        // reset during an access
        mem_auto = 1'b0;
        addr[0] = 8'h07; req[0] = 1'b1;
        tick();
        chk("rm_m_req", 32'(m_req), 32'd1);
        rst = 1'b0; req[0] = 1'b0;
        tick();
        chk("rm_grant", 32'(grant), 32'd0);
        chk("rm_m_req0", 32'(m_req), 32'd0);
        chk("rm_m_addr", 32'(m_addr), 32'd0);
        chk("rm_rdata", 32'({r0_rdata, r1_rdata}), 32'd0);
        exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
        last = 1;
        rst = 1'b1; man_rdy = 1'b1;
        tick();
        man_rdy = 1'b0;
        chk("rm_late_ready", 32'({r0_ready, r1_ready}), 32'd0);
        chk("rm_late_grant", 32'(grant), 32'd0);
        tick();
        chk("rm_late_m_req", 32'(m_req), 32'd0);
        mem_auto = 1'b1;
        tick();

        // random traffic
        for (int it = 0; it < 40; it++) begin
            lat = $urandom_range(0, 3);
            msk = 2'($urandom_range(1, 3));
            for (int r = 0; r < 2; r++) begin
                we[r] = 1'($urandom);
                addr[r] = 8'($urandom);
                wdata[r] = 8'($urandom);
            end
            req = msk;
            w = pick(msk);
            serve(w);
            if (msk == 2'b11) serve(1 - w);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
